// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit MEM stage.
// Holds load-type encodings, stall polarity constants and the FSM state type.
package lsu_pkg;

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LD  = 3'b011;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;
    localparam logic [2:0] LD_LWU = 3'b110;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DONE  = 2'd2,
        S_DRAIN = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// Combinational load lane select and sign/zero extension.
// Ports: ld_op (load type), offset (byte offset), data (raw word), wdata (result).
module load_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]                ld_op,
    input  logic [$clog2(XLEN/8)-1:0] offset,
    input  logic [XLEN-1:0]           data,
    output logic [XLEN-1:0]           wdata
);

    localparam int OW = $clog2(XLEN/8);

    logic [OW-1:0]   base;
    logic [XLEN-1:0] sh;

    // Misaligned offsets round down to the natural lane of the access size.
    always_comb begin
        base = '0;
        unique case (ld_op)
            LD_LB, LD_LBU: base = offset;
            LD_LH, LD_LHU: base = offset & ~OW'(1);
            LD_LW, LD_LWU: base = offset & ~OW'(3);
            default:       base = '0;
        endcase
    end

    assign sh = data >> {base, 3'b000};

    always_comb begin
        wdata = '0;
        unique case (ld_op)
            LD_LB:  wdata = XLEN'($signed(sh[7:0]));
            LD_LH:  wdata = XLEN'($signed(sh[15:0]));
            LD_LW:  wdata = XLEN'($signed(sh[31:0]));
            LD_LBU: wdata = XLEN'(sh[7:0]);
            LD_LHU: wdata = XLEN'(sh[15:0]);
            LD_LWU: wdata = XLEN'(sh[31:0]);
            LD_LD:  if (XLEN == 64) wdata = sh;
            default: wdata = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: registers EX result, waits on data memory, aligns loads.
// Ports: clk/rst, stall/flush, ex_* bus in, dmem_* response, wb_* and fwd_* out.
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RF_AW   = 5,
    parameter int STALL_W = 6,
    parameter int STAGE   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               ex_valid,
    input  logic [31:0]        ex_pc,
    input  logic [XLEN-1:0]    ex_result,
    input  logic               ex_is_load,
    input  logic [2:0]         ex_ld_op,
    input  logic               ex_rf_we,
    input  logic [RF_AW-1:0]   ex_rf_waddr,
    input  logic               dmem_rvalid,
    input  logic [XLEN-1:0]    dmem_rdata,
    output logic               mem_stallreq,
    output logic               wb_valid,
    output logic [31:0]        wb_pc,
    output logic               wb_rf_we,
    output logic [RF_AW-1:0]   wb_rf_waddr,
    output logic [XLEN-1:0]    wb_rf_wdata,
    output logic               fwd_we,
    output logic [RF_AW-1:0]   fwd_waddr,
    output logic [XLEN-1:0]    fwd_wdata,
    output logic               fwd_load_pending
);

    localparam int OW = $clog2(XLEN/8);

    lsu_state_e state, state_nxt;

    logic             valid_r;
    logic [31:0]      pc_r;
    logic [XLEN-1:0]  result_r;
    logic             is_load_r;
    logic [2:0]       ld_op_r;
    logic             rf_we_r;
    logic [RF_AW-1:0] waddr_r;
    logic [XLEN-1:0]  rdata_r;

    logic            bypass;
    logic            advance;
    logic            bubble;
    logic            next_load;
    logic [XLEN-1:0] ld_raw;
    logic [XLEN-1:0] ld_data;
    logic            unused_stall;

    assign unused_stall = ^stall;

    // A response coinciding with a flush belongs to a killed load.
    assign bypass    = (state == S_WAIT) && dmem_rvalid && !flush;
    assign mem_stallreq = ((state == S_WAIT) && !dmem_rvalid)
                        || (state == S_DRAIN);
    assign next_load = ex_valid && ex_is_load;

    // Our own stall request must hold the outstanding load, never bubble it.
    assign advance = !flush && !mem_stallreq && (stall[STAGE] == NO_STOP);
    assign bubble  = flush || (!mem_stallreq
                   && (stall[STAGE] == STOP)
                   && (stall[STAGE+1] == NO_STOP));

    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            valid_r   <= 1'b0;
            pc_r      <= '0;
            result_r  <= '0;
            is_load_r <= 1'b0;
            ld_op_r   <= '0;
            rf_we_r   <= 1'b0;
            waddr_r   <= '0;
        end else if (advance) begin
            valid_r   <= ex_valid;
            pc_r      <= ex_pc;
            result_r  <= ex_result;
            is_load_r <= ex_is_load;
            ld_op_r   <= ex_ld_op;
            rf_we_r   <= ex_rf_we;
            waddr_r   <= ex_rf_waddr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            rdata_r <= '0;
        end else begin
            state <= state_nxt;
            if (bypass) rdata_r <= dmem_rdata;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (advance && next_load) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (flush) begin
                    state_nxt = dmem_rvalid ? S_IDLE : S_DRAIN;
                end else if (dmem_rvalid) begin
                    if (advance)     state_nxt = next_load ? S_WAIT : S_IDLE;
                    else if (bubble) state_nxt = S_IDLE;
                    else             state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (bubble)       state_nxt = S_IDLE;
                else if (advance) state_nxt = next_load ? S_WAIT : S_IDLE;
            end
            S_DRAIN: begin
                if (dmem_rvalid) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign ld_raw = bypass ? dmem_rdata : rdata_r;

    load_align #(.XLEN(XLEN)) u_align (
        .ld_op  (ld_op_r),
        .offset (result_r[OW-1:0]),
        .data   (ld_raw),
        .wdata  (ld_data)
    );

    assign wb_valid    = valid_r
                       && !(is_load_r && (state != S_DONE) && !bypass);
    assign wb_pc       = pc_r;
    assign wb_rf_we    = wb_valid && rf_we_r;
    assign wb_rf_waddr = waddr_r;
    assign wb_rf_wdata = is_load_r ? ld_data : result_r;

    assign fwd_we           = wb_rf_we;
    assign fwd_waddr        = wb_rf_waddr;
    assign fwd_wdata        = wb_rf_wdata;
    assign fwd_load_pending = is_load_r && (state == S_WAIT) && !dmem_rvalid;

    a_rvalid_expected: assert property (
        @(posedge clk) disable iff (rst)
        dmem_rvalid |-> (state == S_WAIT || state == S_DRAIN)
    ) else $error("dmem_rvalid with no load outstanding");

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu at XLEN=32 and XLEN=64.
// Both instances share stimulus; a behavioural load model supplies expectations.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst, flush, ds_stall;
    logic        ex_valid, ex_is_load, ex_rf_we, dmem_rvalid;
    logic [31:0] ex_pc;
    logic [63:0] ex_result, dmem_rdata;
    logic [2:0]  ex_ld_op;
    logic [4:0]  ex_rf_waddr;
    logic [5:0]  stall32, stall64;

    logic        req32, wbv32, wbwe32, fwe32, fpend32;
    logic [31:0] wbpc32, wbwd32, fwd32;
    logic [4:0]  wbwa32, fwa32;
    logic        req64, wbv64, wbwe64, fwe64, fpend64;
    logic [31:0] wbpc64;
    logic [63:0] wbwd64, fwd64;
    logic [4:0]  wbwa64, fwa64;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Stall controller: a MEM request stops stages 0..3, downstream stop stops all.
    assign stall32 = {{2{ds_stall}}, {4{ds_stall | req32}}};
    assign stall64 = {{2{ds_stall}}, {4{ds_stall | req64}}};

    mem_stage_lsu #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst), .stall(stall32), .flush(flush),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_result(ex_result[31:0]),
        .ex_is_load(ex_is_load), .ex_ld_op(ex_ld_op), .ex_rf_we(ex_rf_we),
        .ex_rf_waddr(ex_rf_waddr), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata[31:0]), .mem_stallreq(req32),
        .wb_valid(wbv32), .wb_pc(wbpc32), .wb_rf_we(wbwe32),
        .wb_rf_waddr(wbwa32), .wb_rf_wdata(wbwd32), .fwd_we(fwe32),
        .fwd_waddr(fwa32), .fwd_wdata(fwd32), .fwd_load_pending(fpend32)
    );

    mem_stage_lsu #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .stall(stall64), .flush(flush),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_result(ex_result),
        .ex_is_load(ex_is_load), .ex_ld_op(ex_ld_op), .ex_rf_we(ex_rf_we),
        .ex_rf_waddr(ex_rf_waddr), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata), .mem_stallreq(req64),
        .wb_valid(wbv64), .wb_pc(wbpc64), .wb_rf_we(wbwe64),
        .wb_rf_waddr(wbwa64), .wb_rf_wdata(wbwd64), .fwd_we(fwe64),
        .fwd_waddr(fwa64), .fwd_wdata(fwd64), .fwd_load_pending(fpend64)
    );

    // Load result from the ISA rules: access size, rounded-down lane, extension.
    function automatic logic [63:0] model_load(input int xlen,
        input logic [2:0] op, input logic [63:0] addr, input logic [63:0] raw);
        longint unsigned size, off, lane, mask;
        size = 0;
        case (op)
            3'b000, 3'b100: size = 1;
            3'b001, 3'b101: size = 2;
            3'b010, 3'b110: size = 4;
            3'b011: size = (xlen == 64) ? 8 : 0;
            default: size = 0;
        endcase
        if (size == 0) return 64'd0;
        off = addr % longint'(xlen / 8);
        off = off - (off % size);
        lane = raw >> (off * 8);
        if (size == 8) return lane;
        mask = (64'd1 << (size * 8)) - 1;
        lane = lane & mask;
        if (op[2] == 1'b0 && ((lane >> (size * 8 - 1)) & 1) == 1)
            lane = lane | ~mask;
        if (xlen == 32) lane = lane & 64'hFFFF_FFFF;
        return lane;
    endfunction

    task automatic issue(input bit ld, input logic [2:0] op,
                         input logic [63:0] res, input logic [4:0] wa);
        ex_valid = 1'b1; ex_is_load = ld; ex_ld_op = op;
        ex_result = res; ex_rf_we = 1'b1; ex_rf_waddr = wa;
        ex_pc = $urandom;
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_is_load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; ds_stall = 1'b0;
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_rf_we = 1'b0;
        ex_pc = '0; ex_result = '0; ex_ld_op = '0; ex_rf_waddr = '0;
        dmem_rvalid = 1'b0; dmem_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (wbv32 !== 1'b0) begin n_bad++;
            $display("FAIL reset_wbv32: got %b want 0", wbv32); end
        n_cmp++; if (wbwd32 !== 32'd0) begin n_bad++;
            $display("FAIL reset_wbwd32: got %h want 0", wbwd32); end
        n_cmp++; if (req32 !== 1'b0) begin n_bad++;
            $display("FAIL reset_req32: got %b want 0", req32); end
        n_cmp++; if (fpend32 !== 1'b0 || fwe32 !== 1'b0) begin n_bad++;
            $display("FAIL reset_fwd32: got %b%b want 00", fpend32, fwe32); end
        n_cmp++; if (wbv64 !== 1'b0 || wbwd64 !== 64'd0) begin n_bad++;
            $display("FAIL reset_wb64: got %b %h want 0 0", wbv64, wbwd64); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_nonload();
        issue(1'b0, 3'b000, 64'h1234_5678, 5'd5);
        @(negedge clk);
        n_cmp++; if (wbv32 !== 1'b1 || wbwe32 !== 1'b1) begin n_bad++;
            $display("FAIL nonload_valid: got %b%b want 11", wbv32, wbwe32); end
        n_cmp++; if (wbwd32 !== 32'h1234_5678) begin n_bad++;
            $display("FAIL nonload_wdata: got %h want 12345678", wbwd32); end
        n_cmp++; if (wbwa32 !== 5'd5 || fwa32 !== 5'd5) begin n_bad++;
            $display("FAIL nonload_waddr: got %0d %0d want 5", wbwa32, fwa32); end
        n_cmp++; if (req32 !== 1'b0) begin n_bad++;
            $display("FAIL nonload_req: got %b want 0", req32); end
        n_cmp++; if (fwd32 !== 32'h1234_5678 || fwe32 !== 1'b1) begin n_bad++;
            $display("FAIL nonload_fwd: got %h %b want 12345678 1", fwd32, fwe32); end
        n_cmp++; if (wbwd64 !== 64'h1234_5678) begin n_bad++;
            $display("FAIL nonload_wdata64: got %h want 12345678", wbwd64); end
        @(posedge clk); #1;
    endtask

    task automatic test_align();
        logic [2:0]  op [5] = '{3'b000, 3'b100, 3'b101, 3'b011, 3'b010};
        logic [63:0] ad [5] = '{64'd3, 64'd3, 64'd2, 64'h1000, 64'h1004};
        logic [63:0] rw [5] = '{64'h80FF_0000, 64'h80FF_0000, 64'h80FF_0000,
                                64'h8877_6655_4433_2211, 64'h8000_0001_0000_0000};
        logic [63:0] ex [5] = '{64'hFFFF_FF80, 64'h80, 64'h80FF,
                                64'h8877_6655_4433_2211, 64'hFFFF_FFFF_8000_0001};
        for (int i = 0; i < 5; i++) begin
            issue(1'b1, op[i], ad[i], 5'd10 + 5'(i));
            dmem_rvalid = 1'b1; dmem_rdata = rw[i];
            @(negedge clk);
            n_cmp++; if (req32 !== 1'b0 || wbv32 !== 1'b1) begin n_bad++;
                $display("FAIL align%0d_zero_wait: got %b%b want 01", i, req32, wbv32); end
            if (i < 3) begin
                n_cmp++; if (wbwd32 !== ex[i][31:0]) begin n_bad++;
                    $display("FAIL align%0d_w32: got %h want %h", i, wbwd32, ex[i][31:0]); end
            end else begin
                n_cmp++; if (wbwd64 !== ex[i]) begin n_bad++;
                    $display("FAIL align%0d_w64: got %h want %h", i, wbwd64, ex[i]); end
            end
            n_cmp++; if (wbwd64 !== model_load(64, op[i], ad[i], rw[i])) begin n_bad++;
                $display("FAIL align%0d_m64: got %h want %h", i, wbwd64,
                         model_load(64, op[i], ad[i], rw[i])); end
            @(posedge clk); #1;
            dmem_rvalid = 1'b0;
        end
    endtask

    task automatic test_latency();
        int cnt = 0;
        issue(1'b1, 3'b010, 64'h100, 5'd7);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (req32 === 1'b1) cnt++;
            n_cmp++; if (fpend32 !== 1'b1 || wbv32 !== 1'b0 || wbwe32 !== 1'b0) begin
                n_bad++;
                $display("FAIL lat_wait%0d: got pend=%b v=%b we=%b want 1 0 0",
                         k, fpend32, wbv32, wbwe32); end
            @(posedge clk); #1;
        end
        dmem_rvalid = 1'b1; dmem_rdata = 64'h0000_0000_DEAD_BEEF;
        @(negedge clk);
        n_cmp++; if (cnt !== 3) begin n_bad++;
            $display("FAIL lat_stall_cycles: got %0d want 3", cnt); end
        n_cmp++; if (req32 !== 1'b0 || fpend32 !== 1'b0) begin n_bad++;
            $display("FAIL lat_resp_req: got %b%b want 00", req32, fpend32); end
        n_cmp++; if (wbv32 !== 1'b1 || wbwd32 !== 32'hDEAD_BEEF) begin n_bad++;
            $display("FAIL lat_resp_data: got %b %h want 1 deadbeef", wbv32, wbwd32); end
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        @(negedge clk);
        n_cmp++; if (wbv32 !== 1'b0) begin n_bad++;
            $display("FAIL lat_after: got %b want 0", wbv32); end
        @(posedge clk); #1;
    endtask

    task automatic test_flush_drain();
        issue(1'b1, 3'b010, 64'h200, 5'd9);
        @(negedge clk);
        n_cmp++; if (req32 !== 1'b1) begin n_bad++;
            $display("FAIL drain_w1: got %b want 1", req32); end
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        n_cmp++; if (req32 !== 1'b1 || wbv32 !== 1'b0) begin n_bad++;
            $display("FAIL drain_d1: got req=%b v=%b want 1 0", req32, wbv32); end
        @(posedge clk); #1;
        dmem_rvalid = 1'b1; dmem_rdata = 64'hBAD0_BAD0;
        @(negedge clk);
        n_cmp++; if (req32 !== 1'b1 || wbv32 !== 1'b0 || wbwd32 === 32'hBAD0_BAD0) begin
            n_bad++;
            $display("FAIL drain_d2: got req=%b v=%b d=%h want 1 0 !bad0bad0",
                     req32, wbv32, wbwd32); end
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        @(negedge clk);
        n_cmp++; if (req32 !== 1'b0 || wbv32 !== 1'b0) begin n_bad++;
            $display("FAIL drain_idle: got %b%b want 00", req32, wbv32); end
        @(posedge clk); #1;
        issue(1'b0, 3'b000, 64'h55, 5'd3);
        @(negedge clk);
        n_cmp++; if (wbv32 !== 1'b1 || wbwd32 !== 32'h55) begin n_bad++;
            $display("FAIL drain_next: got %b %h want 1 55", wbv32, wbwd32); end
        @(posedge clk); #1;
    endtask

    task automatic test_flush_rvalid();
        issue(1'b1, 3'b010, 64'h240, 5'd4);
        flush = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 64'h7777_7777;
        @(negedge clk);
        n_cmp++; if (wbv32 !== 1'b0 || wbwe32 !== 1'b0) begin n_bad++;
            $display("FAIL flrv_same: got %b%b want 00", wbv32, wbwe32); end
        @(posedge clk); #1;
        flush = 1'b0; dmem_rvalid = 1'b0;
        @(negedge clk);
        n_cmp++; if (req32 !== 1'b0 || wbv32 !== 1'b0) begin n_bad++;
            $display("FAIL flrv_idle: got %b%b want 00", req32, wbv32); end
        @(posedge clk); #1;
    endtask

    task automatic test_ds_stall();
        issue(1'b1, 3'b010, 64'h300, 5'd11);
        ds_stall = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 64'h1357_2468;
        @(negedge clk);
        n_cmp++; if (wbv32 !== 1'b1 || wbwd32 !== 32'h1357_2468) begin n_bad++;
            $display("FAIL ds_resp: got %b %h want 1 13572468", wbv32, wbwd32); end
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            dmem_rdata = {$urandom, $urandom};
            @(negedge clk);
            n_cmp++; if (wbv32 !== 1'b1 || wbwd32 !== 32'h1357_2468 || req32 !== 1'b0) begin
                n_bad++;
                $display("FAIL ds_hold%0d: got v=%b d=%h r=%b want 1 13572468 0",
                         k, wbv32, wbwd32, req32); end
            @(posedge clk); #1;
        end
        ds_stall = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (wbv32 !== 1'b0) begin n_bad++;
            $display("FAIL ds_advance: got %b want 0", wbv32); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_ld_op = 3'b100;
        ex_result = 64'h401; ex_rf_we = 1'b1; ex_rf_waddr = 5'd12;
        @(posedge clk); #1;
        dmem_rvalid = 1'b1; dmem_rdata = 64'h0000_0000_A1B2_C3D4;
        ex_ld_op = 3'b001; ex_result = 64'h402; ex_rf_waddr = 5'd13;
        @(negedge clk);
        n_cmp++; if (wbv32 !== 1'b1 || wbwd32 !== 32'hC3 || wbwa32 !== 5'd12) begin
            n_bad++;
            $display("FAIL b2b_first: got %b %h %0d want 1 c3 12", wbv32, wbwd32, wbwa32); end
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_is_load = 1'b0;
        dmem_rdata = 64'h0000_0000_9ABC_0000;
        @(negedge clk);
        n_cmp++; if (wbv32 !== 1'b1 || wbwd32 !== 32'hFFFF_9ABC || wbwa32 !== 5'd13) begin
            n_bad++;
            $display("FAIL b2b_second: got %b %h %0d want 1 ffff9abc 13",
                     wbv32, wbwd32, wbwa32); end
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        @(negedge clk);
        n_cmp++; if (wbv32 !== 1'b0 || req32 !== 1'b0) begin n_bad++;
            $display("FAIL b2b_after: got %b%b want 00", wbv32, req32); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            bit          ld   = 1'($urandom % 2);
            logic [2:0]  op   = 3'($urandom % 8);
            logic [63:0] ad   = {$urandom, $urandom};
            logic [63:0] raw  = {$urandom, $urandom};
            logic [4:0]  wa   = 5'($urandom % 32);
            int          lat  = int'($urandom % 4);
            int          cnt  = 0;
            issue(ld, op, ad, wa);
            if (ld) begin
                for (int k = 0; k < lat; k++) begin
                    @(negedge clk);
                    if (req32 === 1'b1 && req64 === 1'b1) cnt++;
                    @(posedge clk); #1;
                end
                dmem_rvalid = 1'b1; dmem_rdata = raw;
            end
            @(negedge clk);
            n_cmp++; if (cnt !== (ld ? lat : 0) || req32 !== 1'b0) begin n_bad++;
                $display("FAIL rnd%0d_stall: got %0d want %0d", it, cnt, ld ? lat : 0); end
            n_cmp++; if (wbv32 !== 1'b1 || wbv64 !== 1'b1 || wbwa32 !== wa) begin n_bad++;
                $display("FAIL rnd%0d_valid: got %b%b %0d want 11 %0d",
                         it, wbv32, wbv64, wbwa32, wa); end
            if (ld) begin
                n_cmp++; if (wbwd32 !== model_load(32, op, ad, raw) >> 0) begin
                    if (wbwd32 !== 32'(model_load(32, op, ad, raw))) begin n_bad++;
                        $display("FAIL rnd%0d_ld32: op=%0d got %h want %h", it, op,
                                 wbwd32, 32'(model_load(32, op, ad, raw))); end
                end
                n_cmp++; if (wbwd64 !== model_load(64, op, ad, raw)) begin n_bad++;
                    $display("FAIL rnd%0d_ld64: op=%0d got %h want %h", it, op,
                             wbwd64, model_load(64, op, ad, raw)); end
            end else begin
                n_cmp++; if (wbwd32 !== ad[31:0] || wbwd64 !== ad) begin n_bad++;
                    $display("FAIL rnd%0d_alu: got %h %h want %h", it, wbwd32, wbwd64, ad); end
            end
            @(posedge clk); #1;
            dmem_rvalid = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_nonload();
        test_align();
        test_latency();
        test_flush_drain();
        test_flush_rvalid();
        test_ds_stall();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
